alu_op_scheduler: RTL and testbench

- Shares the ALU operation sequencers (add, sub, mul, div control units) between two requesters.
- Arbitrates requests round-robin and latches the owner's opcode.
- Launches the selected control unit with a one-cycle begin pulse, then waits for its stop/end flag and returns a done pulse to the owner.
- A watchdog timer aborts operations whose control unit never finishes.

---
 rtl/alu_op_scheduler.sv | 131 +++++++++++++
 tb/tb_alu_op_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: shares the add/sub/mul/div control units between two
// requesters. A round-robin arbiter picks an owner, the chosen unit gets a
// one-cycle begin pulse, and the owner receives a done pulse when the unit
// raises its stop flag or when the watchdog gives up on it.
//
// Handshake: a requester raises reqN (with opN valid) and keeps it high
// until doneN. The opcode is captured only when the grant is decided in
// IDLE, so later opN changes and early req drops have no effect on the
// operation in flight. doneN is a one-cycle pulse; tmo qualifies it.
module alu_op_scheduler #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic       req0,
   input  logic [1:0] op0,
   input  logic       req1,
   input  logic [1:0] op1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic       tmo,
   output logic [3:0] bgn,
   input  logic [3:0] stop,
   output logic       sel_src,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_FIN    = 2'd3
   } state_t;

   // Last watchdog value before the operation is abandoned.
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] WD_MAX  = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic [1:0]       op_q, op_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] wd_q, wd_d;
   logic             tmo_q, tmo_d;

   logic             win0, win1;

   // Round-robin: on a tie the requester that did not own the ALU last wins.
   assign win0 = req0 && (!req1 || last_q);
   assign win1 = req1 && (!req0 || !last_q);

   // State, owner, opcode, watchdog and timeout flag registers.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         op_q    <= 2'b00;
         last_q  <= 1'b1;
         wd_q    <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         op_q    <= op_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
         tmo_q   <= tmo_d;
      end
   end

   // Next-state logic: arbitration, launch, wait for stop or watchdog, finish.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      op_d    = op_q;
      last_d  = last_q;
      wd_d    = wd_q;
      tmo_d   = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (win0) begin
               owner_d = 1'b0;
               op_d    = op0;
               state_d = S_LAUNCH;
            end else if (win1) begin
               owner_d = 1'b1;
               op_d    = op1;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            // Stop flags are not looked at here; the unit only just started.
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A real stop on the final watchdog cycle still counts as success.
            if (stop[op_q]) begin
               tmo_d   = 1'b0;
               state_d = S_FIN;
            end else if (wd_q == WD_LAST) begin
               tmo_d   = 1'b1;
               state_d = S_FIN;
            end else if (wd_q != WD_MAX) begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_FIN: begin
            last_d  = owner_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Moore outputs decoded from the registered state, owner and opcode.
   always_comb begin
      busy    = (state_q != S_IDLE);
      gnt0    = busy && !owner_q;
      gnt1    = busy && owner_q;
      sel_src = busy && owner_q;
      bgn     = (state_q == S_LAUNCH) ? (4'b0001 << op_q) : 4'b0000;
      done0   = (state_q == S_FIN) && !owner_q;
      done1   = (state_q == S_FIN) && owner_q;
      tmo     = (state_q == S_FIN) && tmo_q;
   end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: a table of single-operation vectors, hand-written
// sequences for wrong-unit stops, mid-operation reset and opcode/req changes,
// and a second instance with a short watchdog for the timeout corners.
module tb_alu_op_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance (default watchdog).
   logic       rst_b, req0, req1;
   logic [1:0] op0, op1;
   logic [3:0] stop;
   logic       gnt0, gnt1, done0, done1, tmo, sel_src, busy;
   logic [3:0] bgn;

   // Short-watchdog instance.
   logic       t_rst_b, t_req0, t_req1;
   logic [1:0] t_op0, t_op1;
   logic [3:0] t_stop;
   logic       t_gnt0, t_gnt1, t_done0, t_done1, t_tmo, t_sel_src, t_busy;
   logic [3:0] t_bgn;

   alu_op_scheduler dut (
      .clk(clk), .rst_b(rst_b), .req0(req0), .op0(op0), .req1(req1), .op1(op1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .tmo(tmo),
      .bgn(bgn), .stop(stop), .sel_src(sel_src), .busy(busy)
   );

   alu_op_scheduler #(.TIMEOUT(4), .CNT_W(8)) dut_t (
      .clk(clk), .rst_b(t_rst_b), .req0(t_req0), .op0(t_op0), .req1(t_req1), .op1(t_op1),
      .gnt0(t_gnt0), .gnt1(t_gnt1), .done0(t_done0), .done1(t_done1), .tmo(t_tmo),
      .bgn(t_bgn), .stop(t_stop), .sel_src(t_sel_src), .busy(t_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic mon_en = 1'b0;

   // Scoreboard entries are {owner, tmo} for each completion the main DUT owes.
   logic [1:0] exp_q[$];
   logic [1:0] sb_e;

   typedef struct {
      logic       rst;
      logic       r0;
      logic [1:0] o0;
      logic       r1;
      logic [1:0] o1;
      logic       own;
      logic [3:0] bgn;
      int         n;
      logic [3:0] stp;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: invariants every cycle, and completions popped from the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
         check("bgn_onehot", 32'($onehot0(bgn)), 32'd1);
         if (done0 || done1) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_spurious: got done0=%0b done1=%0b, expected no done", done0, done1);
            end else begin
               sb_e = exp_q.pop_front();
               check("sb_owner", 32'(done1), 32'(sb_e[1]));
               check("sb_tmo", 32'(tmo), 32'(sb_e[0]));
            end
         end
      end
   end

   // One complete operation on the main DUT, starting and ending in IDLE.
   task automatic run_vec(input int k, input vec_t v);
      if (v.rst) begin
         rst_b = 1'b1;
         tick();
         rst_b = 1'b0;
      end
      req0 = v.r0; op0 = v.o0; req1 = v.r1; op1 = v.o1; stop = 4'b0000;
      tick();
      check($sformatf("v%0d_gnt", k), 32'({gnt1, gnt0}), 32'(v.own ? 2'b10 : 2'b01));
      check($sformatf("v%0d_bgn", k), 32'(bgn), 32'(v.bgn));
      check($sformatf("v%0d_sel", k), 32'(sel_src), 32'(v.own));
      check($sformatf("v%0d_busy", k), 32'(busy), 32'd1);
      exp_q.push_back({v.own, 1'b0});
      repeat (v.n + 1) begin
         tick();
         check($sformatf("v%0d_wait_bgn", k), 32'(bgn), 32'd0);
         check($sformatf("v%0d_wait_gnt", k), 32'({gnt1, gnt0}), 32'(v.own ? 2'b10 : 2'b01));
         check($sformatf("v%0d_wait_done", k), 32'({done1, done0}), 32'd0);
      end
      stop = v.stp;
      tick();
      check($sformatf("v%0d_done", k), 32'({done1, done0}), 32'(v.own ? 2'b10 : 2'b01));
      check($sformatf("v%0d_tmo", k), 32'(tmo), 32'd0);
      stop = 4'b0000;
      tick();
      check($sformatf("v%0d_idle", k), 32'(busy), 32'd0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 4'b0010, 6, 4'b0010};
      vecs[1] = '{1'b1, 1'b1, 2'b00, 1'b1, 2'b10, 1'b0, 4'b0001, 5, 4'b0001};
      vecs[2] = '{1'b0, 1'b1, 2'b00, 1'b1, 2'b10, 1'b1, 4'b0100, 5, 4'b0100};
      vecs[3] = '{1'b0, 1'b1, 2'b00, 1'b1, 2'b10, 1'b0, 4'b0001, 5, 4'b0001};
      vecs[4] = '{1'b0, 1'b1, 2'b00, 1'b1, 2'b10, 1'b1, 4'b0100, 5, 4'b0100};
      vecs[5] = '{1'b0, 1'b0, 2'b00, 1'b1, 2'b11, 1'b1, 4'b1000, 2, 4'b1000};
      vecs[6] = '{1'b0, 1'b1, 2'b10, 1'b1, 2'b01, 1'b0, 4'b0100, 0, 4'b0100};
      vecs[7] = '{1'b0, 1'b1, 2'b10, 1'b1, 2'b01, 1'b1, 4'b0010, 3, 4'b1111};

      // Clock/reset.
      rst_b = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 2'b00; op1 = 2'b00; stop = 4'b0000;
      t_rst_b = 1'b1; t_req0 = 1'b0; t_req1 = 1'b0; t_op0 = 2'b00; t_op1 = 2'b00; t_stop = 4'b0000;
      repeat (2) tick();
      check("rst_outs", 32'({gnt0, gnt1, done0, done1, tmo, sel_src, busy}), 32'd0);
      check("rst_bgn", 32'(bgn), 32'd0);
      check("rst_t_outs", 32'({t_gnt0, t_gnt1, t_done0, t_done1, t_tmo, t_busy, t_bgn}), 32'd0);
      rst_b = 1'b0;
      t_rst_b = 1'b0;
      mon_en = 1'b1;

      // Table-driven operations.
      for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

      // Wrong-unit stops are ignored; a stop during LAUNCH is ignored.
      req0 = 1'b1; op0 = 2'b01; req1 = 1'b0; stop = 4'b0010;
      tick();
      check("wu_bgn", 32'(bgn), 32'b0010);
      exp_q.push_back(2'b00);
      stop = 4'b0000;
      tick();
      check("wu_launch_stop", 32'({busy, done0}), 32'b10);
      foreach (vecs[i]) begin
         if (i < 4) begin
            stop = (i == 0) ? 4'b0100 : (i == 1) ? 4'b0001 : (i == 2) ? 4'b1000 : 4'b1101;
            tick();
            check("wu_ignored", 32'({busy, gnt0, done0}), 32'b110);
         end
      end
      stop = 4'b0010;
      tick();
      check("wu_done", 32'({done0, tmo}), 32'b10);
      stop = 4'b0000; req0 = 1'b0;
      tick();
      check("wu_idle", 32'(busy), 32'd0);

      // Reset during WAIT drops everything with no done; req1 then granted.
      req1 = 1'b1; op1 = 2'b10;
      tick();
      check("rw_bgn", 32'(bgn), 32'b0100);
      repeat (3) tick();
      rst_b = 1'b1;
      tick();
      check("rw_outs", 32'({gnt0, gnt1, done0, done1, tmo, busy}), 32'd0);
      check("rw_bgn0", 32'(bgn), 32'd0);
      rst_b = 1'b0; op1 = 2'b00;
      tick();
      check("rw_regrant", 32'({gnt1, gnt0, sel_src}), 32'b101);
      check("rw_regrant_bgn", 32'(bgn), 32'b0001);
      exp_q.push_back(2'b10);
      tick();
      stop = 4'b0001;
      tick();
      check("rw_done1", 32'(done1), 32'd1);
      stop = 4'b0000; req1 = 1'b0;
      tick();

      // Owner drops req and changes op mid-WAIT; latched opcode rules.
      req0 = 1'b1; op0 = 2'b11;
      tick();
      check("dr_bgn", 32'(bgn), 32'b1000);
      exp_q.push_back(2'b00);
      tick();
      req0 = 1'b0; op0 = 2'b00; stop = 4'b0001;
      repeat (2) begin
         tick();
         check("dr_hold", 32'({busy, gnt0, done0, bgn}), 32'b1100000);
      end
      stop = 4'b1000;
      tick();
      check("dr_done", 32'({done0, tmo}), 32'b10);
      stop = 4'b0000;
      tick();
      check("dr_idle", 32'(busy), 32'd0);

      // Watchdog: abort after 4 WAIT cycles, then stop on the final cycle wins.
      t_req0 = 1'b1; t_op0 = 2'b11;
      tick();
      check("to_bgn", 32'({t_gnt0, t_bgn}), 32'b11000);
      repeat (4) begin
         tick();
         check("to_wait", 32'({t_busy, t_done0}), 32'b10);
      end
      tick();
      check("to_abort", 32'({t_done0, t_done1, t_tmo}), 32'b101);
      t_req0 = 1'b0; t_req1 = 1'b1; t_op1 = 2'b00;
      tick();
      check("to_idle", 32'(t_busy), 32'd0);
      tick();
      check("to_next", 32'({t_gnt1, t_gnt0, t_sel_src, t_bgn}), 32'b1010001);
      repeat (4) tick();
      t_stop = 4'b0001;
      tick();
      check("to_last_stop", 32'({t_done1, t_done0, t_tmo}), 32'b100);
      t_stop = 4'b0000; t_req1 = 1'b0;
      tick();
      check("to_final_idle", 32'(t_busy), 32'd0);

      repeat (2) tick();
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
